// File: rtl/id_stall_unit_pkg.sv
// Shared ID-stage pipeline definitions: FSM encoding, stall lengths, register constants.
package id_stall_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned REM_W = 2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [REM_W-1:0] NO_STALL          = REM_W'(0);
  localparam logic [REM_W-1:0] LOAD_USE_STALL    = REM_W'(1);
  localparam logic [REM_W-1:0] BR_ALU_STALL      = REM_W'(1);
  localparam logic [REM_W-1:0] BR_MEM_LOAD_STALL = REM_W'(1);
  localparam logic [REM_W-1:0] BR_LOAD_STALL     = REM_W'(2);

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

  // Larger of two stall requests.
  function automatic logic [REM_W-1:0] max_stall(input logic [REM_W-1:0] a,
                                                 input logic [REM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/id_stall_unit_if.sv
// Hazard inputs and stall/flush controls between the ID stage and the stall unit.
interface id_stall_unit_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [id_stall_unit_pkg::REG_W-1:0] IF_ID_rs;
  logic [id_stall_unit_pkg::REG_W-1:0] IF_ID_rt;
  logic                                IF_ID_UsesRt;
  logic                                IF_ID_Branch;
  logic                                Branch_taken;
  logic                                Jump;
  logic                                ID_EX_MemRead;
  logic                                ID_EX_RegWrite;
  logic [id_stall_unit_pkg::REG_W-1:0] ID_EX_Write_register;
  logic                                EX_MEM_MemRead;
  logic [id_stall_unit_pkg::REG_W-1:0] EX_MEM_Write_register;

  logic                                PC_Write;
  logic                                IF_ID_Write;
  logic                                IF_ID_Flush;
  logic                                ID_EX_Bubble;
  logic                                stall_active;
  logic [CNT_W-1:0]                    stall_cycles;

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_UsesRt, IF_ID_Branch, Branch_taken, Jump,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_register,
           EX_MEM_MemRead, EX_MEM_Write_register,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, stall_active, stall_cycles
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_UsesRt, IF_ID_Branch, Branch_taken, Jump,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_register,
           EX_MEM_MemRead, EX_MEM_Write_register,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, stall_active, stall_cycles
  );

endinterface

// File: rtl/id_stall_unit_hazard_match.sv
// Destination-vs-source match for one producer stage; $0 never creates a dependency.
module hazard_match
  import id_stall_unit_pkg::*;
(
  input  logic [REG_W-1:0] dest_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             uses_rt_i,
  output logic             match_o
);

  assign match_o = (dest_i != ZERO_REG) &&
                   ((dest_i == rs_i) || (uses_rt_i && (dest_i == rt_i)));

endmodule

// File: rtl/id_stall_unit.sv
// ID-stage hazard stall and control-flush controller with stall-cycle counter.
module id_stall_unit
  import id_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  id_stall_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [REM_W-1:0]  n_req;
  logic              ex_match;
  logic              mem_match;
  logic              stall_c;
  logic              flush_req;

  hazard_match u_match_ex (
    .dest_i    (bus.ID_EX_Write_register),
    .rs_i      (bus.IF_ID_rs),
    .rt_i      (bus.IF_ID_rt),
    .uses_rt_i (bus.IF_ID_UsesRt),
    .match_o   (ex_match)
  );

  hazard_match u_match_mem (
    .dest_i    (bus.EX_MEM_Write_register),
    .rs_i      (bus.IF_ID_rs),
    .rt_i      (bus.IF_ID_rt),
    .uses_rt_i (bus.IF_ID_UsesRt),
    .match_o   (mem_match)
  );

  // Required stall length for the instruction in ID; the longest applicable rule wins.
  always_comb begin
    n_req = NO_STALL;
    if (bus.IF_ID_Branch) begin
      if (bus.EX_MEM_MemRead && mem_match)
        n_req = max_stall(n_req, BR_MEM_LOAD_STALL);
      if (bus.ID_EX_RegWrite && !bus.ID_EX_MemRead && ex_match)
        n_req = max_stall(n_req, BR_ALU_STALL);
      if (bus.ID_EX_MemRead && ex_match)
        n_req = max_stall(n_req, BR_LOAD_STALL);
    end else if (bus.ID_EX_MemRead && ex_match) begin
      n_req = LOAD_USE_STALL;
    end
  end

  // State, remaining-stall count and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      rem_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Next state and Mealy stall decision; STALL ignores hazard inputs until rem runs out.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    stall_c        = 1'b0;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      RUN: begin
        if (n_req != NO_STALL) begin
          stall_c = 1'b1;
          rem_d   = n_req - REM_W'(1);
          state_d = (n_req > REM_W'(1)) ? STALL : RUN;
        end
      end
      STALL: begin
        stall_c = 1'b1;
        rem_d   = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1))
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (stall_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // Outputs are forced low while reset is held; a pending stall suppresses the flush.
  assign flush_req        = bus.Jump || (bus.IF_ID_Branch && bus.Branch_taken);
  assign bus.PC_Write     = rst_n && !stall_c;
  assign bus.IF_ID_Write  = rst_n && !stall_c;
  assign bus.ID_EX_Bubble = rst_n && stall_c;
  assign bus.stall_active = rst_n && stall_c;
  assign bus.IF_ID_Flush  = rst_n && flush_req && !stall_c;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_stall_unit.sv
// Scoreboard bench: directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_id_stall_unit;

  logic clk;
  logic rst_n;

  id_stall_unit_if #(.CNT_W(16)) bus16 ();
  id_stall_unit_if #(.CNT_W(2))  bus2 ();

  id_stall_unit #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  id_stall_unit #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.IF_ID_rs              = bus16.IF_ID_rs;
  assign bus2.IF_ID_rt              = bus16.IF_ID_rt;
  assign bus2.IF_ID_UsesRt          = bus16.IF_ID_UsesRt;
  assign bus2.IF_ID_Branch          = bus16.IF_ID_Branch;
  assign bus2.Branch_taken          = bus16.Branch_taken;
  assign bus2.Jump                  = bus16.Jump;
  assign bus2.ID_EX_MemRead         = bus16.ID_EX_MemRead;
  assign bus2.ID_EX_RegWrite        = bus16.ID_EX_RegWrite;
  assign bus2.ID_EX_Write_register  = bus16.ID_EX_Write_register;
  assign bus2.EX_MEM_MemRead        = bus16.EX_MEM_MemRead;
  assign bus2.EX_MEM_Write_register = bus16.EX_MEM_Write_register;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic       jump;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_wr;
    logic       mem_mr;
    logic [4:0] mem_wr;
  } in_t;

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bub;
    logic        stall;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(int rs, int rt, bit ur, bit br, bit tk, bit jp,
                             bit exmr, bit exrw, int exwr, bit mmr, int mwr);
    in_t v;
    v.rs      = 5'(rs);
    v.rt      = 5'(rt);
    v.uses_rt = ur;
    v.br      = br;
    v.taken   = tk;
    v.jump    = jp;
    v.ex_mr   = exmr;
    v.ex_rw   = exrw;
    v.ex_wr   = 5'(exwr);
    v.mem_mr  = mmr;
    v.mem_wr  = 5'(mwr);
    return v;
  endfunction

  task automatic apply(input in_t v);
    bus16.IF_ID_rs              = v.rs;
    bus16.IF_ID_rt              = v.rt;
    bus16.IF_ID_UsesRt          = v.uses_rt;
    bus16.IF_ID_Branch          = v.br;
    bus16.Branch_taken          = v.taken;
    bus16.Jump                  = v.jump;
    bus16.ID_EX_MemRead         = v.ex_mr;
    bus16.ID_EX_RegWrite        = v.ex_rw;
    bus16.ID_EX_Write_register  = v.ex_wr;
    bus16.EX_MEM_MemRead        = v.mem_mr;
    bus16.EX_MEM_Write_register = v.mem_wr;
  endtask

  // One cycle: drive after the rising edge, queue the outputs expected for that cycle.
  task automatic vec(input bit rst, input in_t v, input bit pcw, input bit ifw,
                     input bit fl, input bit bub, input bit st, input int c16, input int c2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    apply(v);
    e.pcw   = pcw;
    e.ifw   = ifw;
    e.flush = fl;
    e.bub   = bub;
    e.stall = st;
    e.cnt16 = 16'(c16);
    e.cnt2  = 2'(c2);
    vec_id++;
    exp_q.push_back(e);
    id_q.push_back(vec_id);
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  initial begin
    exp_t e;
    exp_t a;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        id = id_q.pop_front();
        a.pcw   = bus16.PC_Write;
        a.ifw   = bus16.IF_ID_Write;
        a.flush = bus16.IF_ID_Flush;
        a.bub   = bus16.ID_EX_Bubble;
        a.stall = bus16.stall_active;
        a.cnt16 = bus16.stall_cycles;
        a.cnt2  = bus2.stall_cycles;
        checks++;
        if (a !== e || bus2.PC_Write !== e.pcw || bus2.stall_active !== e.stall) begin
          failures++;
          $display("FAIL vec%0d: got pcw=%b ifw=%b flush=%b bub=%b stall=%b cnt16=%0d cnt2=%0d; expected pcw=%b ifw=%b flush=%b bub=%b stall=%b cnt16=%0d cnt2=%0d",
                   id, a.pcw, a.ifw, a.flush, a.bub, a.stall, a.cnt16, a.cnt2,
                   e.pcw, e.ifw, e.flush, e.bub, e.stall, e.cnt16, e.cnt2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t idle;
    idle  = '0;
    rst_n = 1'b0;
    apply(idle);

    // reset state
    vec(0, idle, 0,0,0,0,0, 0,0);
    vec(0, idle, 0,0,0,0,0, 0,0);
    vec(1, idle, 1,1,0,0,0, 0,0);
    // load-use: one stall
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 0,0);
    vec(1, idle,                       1,1,0,0,0, 1,1);
    // branch after load: two stalls, flush suppressed, then flush
    vec(1, mk(0,9,1,1,1,0,1,0,9,0,0), 0,0,0,1,1, 1,1);
    vec(1, mk(0,9,1,1,1,0,1,0,9,0,0), 0,0,0,1,1, 2,2);
    vec(1, mk(0,9,1,1,1,0,0,0,0,0,0), 1,1,1,0,0, 3,3);
    // rt not read: no dependency
    vec(1, mk(3,9,0,1,1,0,1,0,9,0,0), 1,1,1,0,0, 3,3);
    // branch after ALU op
    vec(1, mk(5,0,0,1,1,0,0,1,5,0,0), 0,0,0,1,1, 3,3);
    vec(1, mk(5,0,0,1,1,0,0,0,0,0,0), 1,1,1,0,0, 4,3);
    vec(1, idle,                       1,1,0,0,0, 4,3);
    // branch with load in MEM
    vec(1, mk(0,7,1,1,0,0,0,0,0,1,7), 0,0,0,1,1, 4,3);
    vec(1, idle,                       1,1,0,0,0, 5,3);
    // non-branch cases that forwarding covers
    vec(1, mk(6,0,0,0,0,0,0,1,6,0,0), 1,1,0,0,0, 5,3);
    vec(1, mk(6,0,0,0,0,0,0,0,0,1,6), 1,1,0,0,0, 5,3);
    // jump flush, and jump flush suppressed by load-use stall
    vec(1, mk(0,0,0,0,0,1,0,0,0,0,0), 1,1,1,0,0, 5,3);
    vec(1, mk(4,0,0,0,0,1,1,0,4,0,0), 0,0,0,1,1, 5,3);
    vec(1, idle,                       1,1,0,0,0, 6,3);
    // register $0 never stalls
    vec(1, mk(0,0,0,0,0,0,1,0,0,0,0), 1,1,0,0,0, 6,3);
    // EX load and MEM load both match: longest stall wins
    vec(1, mk(3,0,0,1,0,0,1,0,3,1,3), 0,0,0,1,1, 6,3);
    vec(1, mk(3,0,0,1,0,0,1,0,3,1,3), 0,0,0,1,1, 7,3);
    vec(1, idle,                       1,1,0,0,0, 8,3);
    // reset in second stall cycle
    vec(1, mk(0,9,1,1,1,0,1,0,9,0,0), 0,0,0,1,1, 8,3);
    vec(0, mk(0,9,1,1,1,0,1,0,9,0,0), 0,0,0,0,0, 0,0);
    vec(1, idle,                       1,1,0,0,0, 0,0);
    // back-to-back load-use stalls: 2-bit counter saturates at 3
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 0,0);
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 1,1);
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 2,2);
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 3,3);
    vec(1, mk(8,0,0,0,0,0,1,0,8,0,0), 0,0,0,1,1, 4,3);
    vec(1, idle,                       1,1,0,0,0, 5,3);
    vec(1, idle,                       1,1,0,0,0, 5,3);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stall_unit.md
# id_stall_unit

Hazard-stall and control-flush controller for the ID stage of the 5-stage MIPS pipeline. It sits beside the ID-stage forwarding mux logic. It detects dependencies that forwarding cannot cover in the current cycle: load-use, and branch operands still in EX or in a load in MEM. It then freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches or jumps. A small FSM with a down-counter sequences multi-cycle stalls, and a saturating counter records total stall cycles for performance monitoring.

## Interface
- CNT_W, 16, width of stall-cycle performance counter
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_rs, IF_ID_rt  in  5 each  source registers of instruction in ID
- IF_ID_UsesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- IF_ID_Branch  in  1  ID instruction is beq/bne (compared in ID)
- Branch_taken  in  1  ID comparator result, meaningful only with IF_ID_Branch
- Jump  in  1  ID instruction is j/jal/jr
- ID_EX_MemRead, ID_EX_RegWrite  in  1 each  EX-stage instruction controls
- ID_EX_Write_register  in  5  EX-stage destination
- EX_MEM_MemRead  in  1  MEM-stage instruction is a load
- EX_MEM_Write_register  in  5  MEM-stage destination
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  clear IF/ID to nop next edge
- ID_EX_Bubble  out  1  zero ID/EX control fields next edge
- stall_active  out  1  high in every stall cycle
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Register match rule: dest != 0 and (dest == rs, or dest == rt and IF_ID_UsesRt).
- Required stall N, evaluated only in state RUN:
  - Branch and ID_EX_MemRead and match(ID_EX) -> N=2.
  - Branch and ID_EX_RegWrite and not ID_EX_MemRead and match(ID_EX) -> N=1.
  - Branch and EX_MEM_MemRead and match(EX_MEM) -> N=1.
  - Non-branch, ID_EX_MemRead and match(ID_EX) -> N=1.
  - Otherwise N=0. When several rules apply, the largest N wins.
- States: RUN, STALL. The counter rem is 2 bits.
  - RUN, N=0: PC_Write=IF_ID_Write=1, ID_EX_Bubble=0, stall_active=0.
  - RUN, N>0: stall asserted in the same cycle (Mealy), meaning PC_Write=IF_ID_Write=0, ID_EX_Bubble=1, stall_active=1. rem <= N-1. Next state is STALL if N-1>0, else RUN.
  - STALL: stall asserted and hazard inputs ignored. rem decrements. When rem==1, next state is RUN.
- Flush: IF_ID_Flush = (Jump or (IF_ID_Branch and Branch_taken)) and not stall_active.
  - Stall and flush requested together: stall wins and the flush is suppressed. The branch is re-evaluated once operands are forwardable.
- stall_cycles increments by 1 every cycle stall_active=1. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, rem=0, stall_cycles=0. While rst_n is low, all outputs are forced to 0, including PC_Write and IF_ID_Write.
- First cycle after release: outputs follow the RUN equations.
- Stall outputs are combinational from the current state and ID inputs. They are valid before the same rising edge that would otherwise advance the pipeline.
- A stall of N lasts exactly N consecutive cycles. Re-detection is only possible in the cycle after the return to RUN.
- Reset asserted mid-stall aborts the stall immediately. Nothing is held over.
- Output stall_cycles updates on the edge ending each stall cycle (1-cycle latency).

## Structure
- Shared pipeline package: state encoding (RUN=1'b0, STALL=1'b1), stall lengths LOAD_USE_STALL=1, BR_ALU_STALL=1, BR_LOAD_STALL=2, and the zero register constant.
- One natural sub-module, hazard_match: purely combinational, computing the match rule for one (dest, rs, rt, UsesRt) tuple. It is instantiated twice, for ID_EX and EX_MEM.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Write_register=8, rs=8, branch=0 -> one cycle of PC_Write=0, ID_EX_Bubble=1; stall_cycles 0->1.
- Branch after load: IF_ID_Branch=1, ID_EX_MemRead=1, dest=9=rt, UsesRt=1 -> exactly 2 stall cycles (RUN->STALL->RUN), IF_ID_Flush=0 throughout even with Branch_taken=1.
- Branch after ALU op: ID_EX_RegWrite=1, dest=5=rs, Branch_taken=1 -> 1 stall cycle, then with no hazard IF_ID_Flush=1 for one cycle.
- Register $0: ID_EX_MemRead=1, dest=0, rs=0 -> no stall, PC_Write=1.
- Reset during stall: trigger N=2, assert rst_n=0 in the second stall cycle -> all outputs 0 immediately. After release, state is RUN and stall_cycles=0.
- Saturation with CNT_W=2: run 5 stall cycles -> stall_cycles holds 3.
